// File: rtl/fprint_pio_pkg.sv
// ============================================================================
// fprint_pio_pkg : shared types, reset constants and sizing helper for the
//                  fingerprint-gated PIO commit buffer (macro FPRINT_PIO_VOTE_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

package fprint_pio_pkg;

  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_TASK_W    = 4;
  localparam int DEF_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  // Slot record at the default geometry; the slot module re-declares it at its own widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_TASK_W-1:0] tid;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

  function automatic int timer_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fprint_gated_pio_if.sv
// ============================================================================
// fprint_gated_pio_if : core write, comparator release and status bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface fprint_gated_pio_if #(
  parameter int NUM_CORES = 2,
  parameter int DATA_W    = 4,
  parameter int TASK_W    = 4
);
  logic [NUM_CORES-1:0]        core_wr_en;
  logic [NUM_CORES*TASK_W-1:0] core_wr_task;
  logic [NUM_CORES*DATA_W-1:0] core_wr_data;
  logic                        io_release;
  logic [TASK_W-1:0]           io_key;
  logic                        clr_err;
  logic [DATA_W-1:0]           pio_external;
  logic                        release_ok;
  logic                        release_err;
  logic                        data_mismatch;
  logic                        timeout_err;
  logic                        busy;

  modport master (
    output core_wr_en, core_wr_task, core_wr_data, io_release, io_key, clr_err,
    input  pio_external, release_ok, release_err, data_mismatch, timeout_err, busy
  );

  modport slave (
    input  core_wr_en, core_wr_task, core_wr_data, io_release, io_key, clr_err,
    output pio_external, release_ok, release_err, data_mismatch, timeout_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/fprint_pio_slot.sv
// ============================================================================
// fprint_pio_slot : one core's pending {valid, task, data}; a write beats a clear
// Revision 1.0
// ============================================================================
`default_nettype none

module fprint_pio_slot #(
  parameter int DATA_W = 4,
  parameter int TASK_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [TASK_W-1:0] wr_task_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic [TASK_W-1:0] key_i,
  output logic              valid_o,
  output logic              valid_d_o,
  output logic [DATA_W-1:0] data_o,
  output logic              key_match_o
);

  typedef struct packed {
    logic              valid;
    logic [TASK_W-1:0] tid;
    logic [DATA_W-1:0] data;
  } slot_rec_t;

  slot_rec_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (wr_en_i) begin
      slot_d.valid = 1'b1;
      slot_d.tid   = wr_task_i;
      slot_d.data  = wr_data_i;
    end else if (clr_i) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign valid_o     = slot_q.valid;
  assign valid_d_o   = slot_d.valid;
  assign data_o      = slot_q.data;
  assign key_match_o = slot_q.valid && (slot_q.tid == key_i);

endmodule

`default_nettype wire

// File: rtl/fprint_gated_pio.sv
// ============================================================================
// fprint_gated_pio : redundant-core commit buffer releasing a PIO value on a
//                    matching comparator key. Optional macro FPRINT_PIO_VOTE_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module fprint_gated_pio
  import fprint_pio_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TASK_W    = DEF_TASK_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic               osc_clk,
  input logic               reset_n,
  fprint_gated_pio_if.slave bus
);

  localparam int               TMR_W    = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [NUM_CORES-1:0]        slot_valid;
  logic [NUM_CORES-1:0]        slot_valid_d;
  logic [NUM_CORES-1:0]        slot_match;
  logic [NUM_CORES-1:0]        slot_clr;
  logic [NUM_CORES*DATA_W-1:0] slot_data;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] pio_q, pio_d;
  logic              ok_q, err_q, mism_q, terr_q, busy_q;
  logic              terr_d, mism_d;

  logic all_match, votes_equal, accept, reject, timeout_hit;

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      fprint_pio_slot #(
        .DATA_W (DATA_W),
        .TASK_W (TASK_W)
      ) u_slot (
        .clk_i       (osc_clk),
        .rst_ni      (reset_n),
        .wr_en_i     (bus.core_wr_en[i]),
        .wr_task_i   (bus.core_wr_task[i*TASK_W +: TASK_W]),
        .wr_data_i   (bus.core_wr_data[i*DATA_W +: DATA_W]),
        .clr_i       (slot_clr[i]),
        .key_i       (bus.io_key),
        .valid_o     (slot_valid[i]),
        .valid_d_o   (slot_valid_d[i]),
        .data_o      (slot_data[i*DATA_W +: DATA_W]),
        .key_match_o (slot_match[i])
      );
    end
  endgenerate

`ifdef FPRINT_PIO_VOTE_EN
  always_comb begin
    votes_equal = 1'b1;
    for (int i = 1; i < NUM_CORES; i++) begin
      if (slot_data[i*DATA_W +: DATA_W] != slot_data[DATA_W-1:0]) begin
        votes_equal = 1'b0;
      end
    end
  end
  assign mism_d = bus.io_release && all_match && !votes_equal;
`else
  logic unused_vote_data;
  assign unused_vote_data = ^slot_data[NUM_CORES*DATA_W-1:DATA_W];
  assign votes_equal      = 1'b1;
  assign mism_d           = 1'b0;
`endif

  // Release decision reads only the pre-write slot registers.
  always_comb begin
    all_match   = &slot_match;
    accept      = bus.io_release && all_match && votes_equal;
    reject      = bus.io_release && !accept;
    timeout_hit = (state_q != ST_IDLE) && (timer_q == TMR_LAST) && !bus.io_release;
    slot_clr    = '0;
    if (accept || timeout_hit) begin
      slot_clr = '1;
    end else if (reject) begin
      slot_clr = slot_match;
    end
    pio_d  = accept ? slot_data[DATA_W-1:0] : pio_q;
    terr_d = terr_q;
    if (timeout_hit) begin
      terr_d = 1'b1;
    end else if (bus.clr_err) begin
      terr_d = 1'b0;
    end
  end

  // Next state follows post-write occupancy so a write racing a commit keeps its slot live.
  always_comb begin
    state_d = ST_COLLECT;
    if (slot_valid_d == '0) begin
      state_d = ST_IDLE;
    end else if (&slot_valid_d) begin
      state_d = ST_FULL;
    end
    timer_d = timer_q + 1'b1;
    if ((state_q == ST_IDLE) || accept || timeout_hit || (state_d == ST_IDLE)) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      timer_q <= '0;
      pio_q   <= '0;
      ok_q    <= RST_FLAG;
      err_q   <= RST_FLAG;
      mism_q  <= RST_FLAG;
      terr_q  <= RST_FLAG;
      busy_q  <= RST_FLAG;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pio_q   <= pio_d;
      ok_q    <= accept;
      err_q   <= reject;
      mism_q  <= mism_d;
      terr_q  <= terr_d;
      busy_q  <= |slot_valid_d;
    end
  end

  assign bus.pio_external  = pio_q;
  assign bus.release_ok    = ok_q;
  assign bus.release_err   = err_q;
  assign bus.data_mismatch = mism_q;
  assign bus.timeout_err   = terr_q;
  assign bus.busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fprint_gated_pio.sv
// ============================================================================
// tb_fprint_gated_pio : vector table, hand sequences and randomized run against
//                       a slot/age reference model (honours FPRINT_PIO_VOTE_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fprint_gated_pio;
  import fprint_pio_pkg::*;

  localparam int N  = 2;
  localparam int DW = 4;
  localparam int TW = 4;
  localparam int TO = 16;

  logic osc_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 osc_clk = ~osc_clk;

  fprint_gated_pio_if #(.NUM_CORES(N), .DATA_W(DW), .TASK_W(TW)) bus ();

  fprint_gated_pio #(
    .NUM_CORES (N),
    .DATA_W    (DW),
    .TASK_W    (TW),
    .TIMEOUT   (TO)
  ) dut (
    .osc_clk (osc_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wr, input logic [3:0] t0, input logic [3:0] d0,
                       input logic [3:0] t1, input logic [3:0] d1,
                       input logic rel, input logic [3:0] key, input logic clr);
    bus.core_wr_en   = wr;
    bus.core_wr_task = {t1, t0};
    bus.core_wr_data = {d1, d0};
    bus.io_release   = rel;
    bus.io_key       = key;
    bus.clr_err      = clr;
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // Reference model: slot contents plus the age of the oldest pending commit.
  bit       m_valid [N];
  int       m_tid   [N];
  int       m_data  [N];
  int       m_age;
  int       m_pio;
  bit       m_ok, m_err, m_mism, m_terr, m_busy;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tid[i] = 0; m_data[i] = 0;
    end
    m_age = 0; m_pio = 0;
    m_ok = 0; m_err = 0; m_mism = 0; m_terr = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit all_match, same, any_now, any_next, acc, rej, tmo;
    int key;
    key = int'(bus.io_key);
    all_match = 1; same = 1; any_now = 0;
    for (int i = 0; i < N; i++) begin
      if (!(m_valid[i] && m_tid[i] == key)) all_match = 0;
      if (m_data[i] != m_data[0]) same = 0;
      if (m_valid[i]) any_now = 1;
    end
`ifdef FPRINT_PIO_VOTE_EN
    acc = bus.io_release && all_match && same;
    m_mism = bus.io_release && all_match && !same;
`else
    acc = bus.io_release && all_match;
    m_mism = 0;
`endif
    rej = bus.io_release && !acc;
    tmo = any_now && (m_age == TO - 1) && !bus.io_release;
    m_ok = acc;
    m_err = rej;
    if (acc) m_pio = m_data[0];
    if (tmo) m_terr = 1;
    else if (bus.clr_err) m_terr = 0;
    any_next = 0;
    for (int i = 0; i < N; i++) begin
      if (acc || tmo || (rej && m_valid[i] && m_tid[i] == key)) m_valid[i] = 0;
      if (bus.core_wr_en[i]) begin
        m_valid[i] = 1;
        m_tid[i]   = int'(bus.core_wr_task[i*TW +: TW]);
        m_data[i]  = int'(bus.core_wr_data[i*DW +: DW]);
      end
      if (m_valid[i]) any_next = 1;
    end
    if (!any_now || acc || tmo || !any_next) m_age = 0;
    else if (m_age < TO - 1) m_age++;
    m_busy = any_next;
  endtask

  typedef struct {
    logic [1:0] wr;
    logic [3:0] t0, d0, t1, d1;
    logic       rel;
    logic [3:0] key;
    logic [3:0] pio;
    logic       ok, err, mism, busy;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [3:0] p12;
    logic [8:0] act, exp;

    idle();
    #12;
    check("reset_pio",  bus.pio_external, 0);
    check("reset_ok",   bus.release_ok, 0);
    check("reset_err",  bus.release_err, 0);
    check("reset_terr", bus.timeout_err, 0);
    check("reset_busy", bus.busy, 0);
    reset_n = 1'b1;

`ifdef FPRINT_PIO_VOTE_EN
    p12 = 4'hF;
`else
    p12 = 4'h5;
`endif
    //            wr     t0    d0    t1    d1    rel key   pio   ok err mism busy
    tbl[0]  = '{2'b11, 4'd3, 4'hA, 4'd3, 4'hA, 0, 4'd0, 4'h0, 0, 0, 0, 1};
    tbl[1]  = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd3, 4'hA, 1, 0, 0, 0};
    tbl[2]  = '{2'b01, 4'd3, 4'h7, 4'd0, 4'h0, 0, 4'd0, 4'hA, 0, 0, 0, 1};
    tbl[3]  = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd3, 4'hA, 0, 1, 0, 0};
    tbl[4]  = '{2'b11, 4'd2, 4'h1, 4'd5, 4'h2, 0, 4'd0, 4'hA, 0, 0, 0, 1};
    tbl[5]  = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd5, 4'hA, 0, 1, 0, 1};
    tbl[6]  = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd2, 4'hA, 0, 1, 0, 0};
    tbl[7]  = '{2'b01, 4'd1, 4'h3, 4'd0, 4'h0, 0, 4'd0, 4'hA, 0, 0, 0, 1};
    tbl[8]  = '{2'b01, 4'd1, 4'hF, 4'd0, 4'h0, 1, 4'd1, 4'hA, 0, 1, 0, 1};
    tbl[9]  = '{2'b10, 4'd0, 4'h0, 4'd1, 4'hF, 0, 4'd0, 4'hA, 0, 0, 0, 1};
    tbl[10] = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd1, 4'hF, 1, 0, 0, 0};
    tbl[11] = '{2'b11, 4'd4, 4'h5, 4'd4, 4'h6, 0, 4'd0, 4'hF, 0, 0, 0, 1};
`ifdef FPRINT_PIO_VOTE_EN
    tbl[12] = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd4, 4'hF, 0, 1, 1, 0};
`else
    tbl[12] = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd4, 4'h5, 1, 0, 0, 0};
`endif
    tbl[13] = '{2'b11, 4'd6, 4'h9, 4'd6, 4'h9, 0, 4'd0, p12,  0, 0, 0, 1};
    tbl[14] = '{2'b01, 4'd6, 4'h8, 4'd0, 4'h0, 1, 4'd6, 4'h9, 1, 0, 0, 1};
    tbl[15] = '{2'b10, 4'd0, 4'h0, 4'd6, 4'h8, 0, 4'd0, 4'h9, 0, 0, 0, 1};
    tbl[16] = '{2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1, 4'd6, 4'h8, 1, 0, 0, 0};

    tick();
    for (int r = 0; r < 17; r++) begin
      drive(tbl[r].wr, tbl[r].t0, tbl[r].d0, tbl[r].t1, tbl[r].d1, tbl[r].rel, tbl[r].key, 1'b0);
      tick();
      check($sformatf("vec%0d_pio", r),  bus.pio_external,  tbl[r].pio);
      check($sformatf("vec%0d_ok", r),   bus.release_ok,    tbl[r].ok);
      check($sformatf("vec%0d_err", r),  bus.release_err,   tbl[r].err);
      check($sformatf("vec%0d_mism", r), bus.data_mismatch, tbl[r].mism);
      check($sformatf("vec%0d_busy", r), bus.busy,          tbl[r].busy);
      check($sformatf("vec%0d_terr", r), bus.timeout_err,   0);
    end

    // Partial commit left to expire.
    drive(2'b01, 4'd7, 4'h1, 4'd0, 4'h0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) begin
        check("tmo_before_err",  bus.timeout_err, 0);
        check("tmo_before_busy", bus.busy, 1);
      end
    end
    check("tmo_err",  bus.timeout_err, 1);
    check("tmo_busy", bus.busy, 0);
    check("tmo_pio",  bus.pio_external, 4'h8);
    drive(2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    check("clr_err", bus.timeout_err, 0);

    // clr_err coinciding with a fresh timeout: the set wins.
    drive(2'b10, 4'd0, 4'h0, 4'd7, 4'h2, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    for (int k = 1; k < TO; k++) tick();
    drive(2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    check("clr_vs_set", bus.timeout_err, 1);
    drive(2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    check("clr_after", bus.timeout_err, 0);

    // Release arriving on the timeout cycle takes priority.
    drive(2'b11, 4'd2, 4'h3, 4'd2, 4'h3, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    for (int k = 1; k < TO; k++) tick();
    drive(2'b00, 4'd0, 4'h0, 4'd0, 4'h0, 1'b1, 4'd2, 1'b0);
    tick();
    check("tmo_rel_ok",   bus.release_ok, 1);
    check("tmo_rel_terr", bus.timeout_err, 0);
    check("tmo_rel_pio",  bus.pio_external, 4'h3);

    // Reset mid-COLLECT.
    drive(2'b01, 4'd5, 4'h9, 4'd0, 4'h0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    check("mid_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pio",  bus.pio_external, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ok",   bus.release_ok, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", bus.busy, 0);

    // Randomized run against the reference model.
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      drive(2'($urandom_range(3)) & {$urandom_range(1) == 0, $urandom_range(1) == 0},
            4'($urandom_range(3)), 4'($urandom_range(15)),
            4'($urandom_range(3)), 4'($urandom_range(15)),
            1'($urandom_range(9) < 3), 4'($urandom_range(3)),
            1'($urandom_range(19) == 0));
      model_step();
      tick();
      act = {bus.pio_external, bus.release_ok, bus.release_err, bus.data_mismatch,
             bus.timeout_err, bus.busy};
      exp = {4'(m_pio), m_ok, m_err, m_mism, m_terr, m_busy};
      if (act !== exp) begin
        n_fail++;
        $display("FAIL rand_cycle%0d {pio,ok,err,mism,terr,busy}: got 0x%0h expected 0x%0h",
                 c, act, exp);
      end
      n_tests++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
